// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader: output buffer depth and counter widths.
// Also provides a helper that sums buffered and in-flight entries.
package fifo_stream_reader_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int LEVEL_W   = 2;
    localparam int OCC_W     = 3;

    // Buffered plus in-flight entries. The width is chosen so the sum cannot wrap.
    function automatic logic [OCC_W-1:0] occ_of(input logic [LEVEL_W-1:0] level,
                                                input logic               inflight);
        return OCC_W'(level) + OCC_W'(inflight);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_stream_buf2.sv
// Two-entry circular output buffer with head/tail pointers and an occupancy count.
// Reset clears the storage; clear drops only the pointers and the count.
module stream_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   rd_data,
    output logic               valid,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0]   mem [BUF_DEPTH];
    logic               head;
    logic               tail;
    logic [LEVEL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= 1'b0;
            tail <= 1'b0;
            cnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head <= 1'b0;
            tail <= 1'b0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + LEVEL_W'(1);
                2'b01:   cnt <= cnt - LEVEL_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[head];
    assign valid   = (cnt != '0);
    assign level   = cnt;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a single-clock FIFO with one-cycle read latency and presents its entries as a valid/ready stream.
// A read is issued only when the output buffer is guaranteed to have room for the returning word.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    output logic               fifo_rd_en,
    input  logic [WIDTH-1:0]   fifo_dout,
    input  logic               fifo_empty,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_data,
    input  logic               m_ready,
    output logic [LEVEL_W-1:0] level
);

    logic             inflight;
    logic             pop;
    logic             capture;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_after_pop;

    assign pop           = m_valid && m_ready;
    assign occ           = occ_of(level, inflight);
    assign occ_after_pop = occ - OCC_W'(pop);

    // m_ready reaches fifo_rd_en combinationally. This lets a read be issued in the same cycle
    // as a pop, which is what allows one transfer per cycle.
    assign fifo_rd_en = rst_n && !flush && !fifo_empty && (occ_after_pop < OCC_W'(BUF_DEPTH));

    // A word that returns during a flush is dropped.
    assign capture = inflight && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    stream_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .wr_en   (capture),
        .wr_data (fifo_dout),
        .pop     (pop),
        .rd_data (m_data),
        .valid   (m_valid),
        .level   (level)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) occ <= OCC_W'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader. A small behavioural sync FIFO drives the read port.
module tb_fifo_stream_reader;

    localparam int WIDTH = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             m_ready;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       level;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .level      (level)
    );

    // Behavioural FIFO model: registered dout, one-cycle read latency
    logic [WIDTH-1:0] fmem [16];
    logic [3:0]       wp, rp;
    logic [4:0]       cnt;
    logic             f_wr, f_clr;
    logic [WIDTH-1:0] f_wdata;
    logic             rd_fire;

    assign fifo_empty = (cnt == 5'd0);
    assign rd_fire    = fifo_rd_en && (cnt != 5'd0);

    always @(posedge clk) begin
        if (f_clr) begin
            wp        <= 4'd0;
            rp        <= 4'd0;
            cnt       <= 5'd0;
            fifo_dout <= '0;
        end else begin
            if (f_wr) begin
                fmem[wp] <= f_wdata;
                wp       <= wp + 4'd1;
            end
            if (rd_fire) begin
                fifo_dout <= fmem[rp];
                rp        <= rp + 4'd1;
            end
            cnt <= cnt + 5'(f_wr) - 5'(rd_fire);
        end
    end

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int empty_rd = 0;
    logic [WIDTH-1:0] got[$];

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) empty_rd++;
        if (rst_n && !flush && m_valid && m_ready) got.push_back(m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        f_wr    = 1'b1;
        f_wdata = d;
        tick();
        f_wr    = 1'b0;
    endtask

    task automatic fifo_clear();
        f_clr = 1'b1;
        tick();
        f_clr = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            push(9'h050 + 9'(i));
            total++;
            if (fifo_rd_en !== 1'b0) begin
                bad++; $display("FAIL reset_rd_en cyc=%0d got=%b want=0", i, fifo_rd_en);
            end
            total++;
            if (m_valid !== 1'b0) begin
                bad++; $display("FAIL reset_m_valid cyc=%0d got=%b want=0", i, m_valid);
            end
            total++;
            if (m_data !== 9'h000) begin
                bad++; $display("FAIL reset_m_data cyc=%0d got=%h want=000", i, m_data);
            end
            total++;
            if (level !== 2'd0) begin
                bad++; $display("FAIL reset_level cyc=%0d got=%0d want=0", i, level);
            end
        end
    endtask

    task automatic test_streaming();
        int base, rd0, n;
        fifo_clear();
        for (int i = 1; i <= 8; i++) push(9'(i));
        m_ready = 1'b1;
        base = got.size();
        rd0 = rd_cnt;
        rst_n = 1'b1;
        #1;
        total++;
        if (fifo_rd_en !== 1'b1) begin
            bad++; $display("FAIL stream_first_issue got=%b want=1", fifo_rd_en);
        end
        tick();
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL stream_c1_valid got=%b want=0", m_valid);
        end
        tick();
        total++;
        if (m_valid !== 1'b1 || m_data !== 9'h001) begin
            bad++; $display("FAIL stream_c2 got valid=%b data=%h want 1/001", m_valid, m_data);
        end
        repeat (8) tick();
        n = got.size() - base;
        total++;
        if (n !== 8) begin
            bad++; $display("FAIL stream_count got=%0d want=8", n);
        end
        for (int i = 0; i < n && i < 8; i++) begin
            total++;
            if (got[base+i] !== 9'(i + 1)) begin
                bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", i, got[base+i], 9'(i + 1));
            end
        end
        total++;
        if (m_valid !== 1'b0 || level !== 2'd0 || fifo_empty !== 1'b1) begin
            bad++; $display("FAIL stream_drained got valid=%b level=%0d empty=%b want 0/0/1",
                            m_valid, level, fifo_empty);
        end
        total++;
        if (rd_cnt - rd0 !== 8) begin
            bad++; $display("FAIL stream_reads got=%0d want=8", rd_cnt - rd0);
        end
    endtask

    task automatic test_backpressure();
        int base, rd0, n;
        logic [WIDTH-1:0] held;
        m_ready = 1'b0;
        base = got.size();
        rd0 = rd_cnt;
        for (int i = 0; i < 6; i++) push(9'h0A0 + 9'(i));
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c >= 4) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== 9'h0A0) begin
                    bad++; $display("FAIL bp_stable c=%0d got valid=%b data=%h want 1/0a0", c, m_valid, m_data);
                end
            end
        end
        total++;
        if (rd_cnt - rd0 !== 2) begin
            bad++; $display("FAIL bp_reads got=%0d want=2", rd_cnt - rd0);
        end
        total++;
        if (level !== 2'd2 || fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL bp_full got level=%0d rd_en=%b want 2/0", level, fifo_rd_en);
        end
        for (int c = 0; c < 40 && (got.size() - base) < 6; c++) begin
            m_ready = (c % 2 == 0);
            #1;
            if (m_valid && !m_ready) begin
                held = m_data;
                tick();
                total++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    bad++; $display("FAIL bp_hold got valid=%b data=%h want 1/%h", m_valid, m_data, held);
                end
            end else begin
                tick();
            end
        end
        m_ready = 1'b0;
        repeat (4) tick();
        n = got.size() - base;
        total++;
        if (n !== 6) begin
            bad++; $display("FAIL bp_count got=%0d want=6", n);
        end
        for (int i = 0; i < n && i < 6; i++) begin
            total++;
            if (got[base+i] !== 9'h0A0 + 9'(i)) begin
                bad++; $display("FAIL bp_data idx=%0d got=%h want=%h", i, got[base+i], 9'h0A0 + 9'(i));
            end
        end
    endtask

    task automatic test_empty_boundary();
        int base, rd0, n;
        m_ready = 1'b1;
        tick();
        base = got.size();
        rd0 = rd_cnt;
        total++;
        if (fifo_empty !== 1'b1 || fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL empty_idle got empty=%b rd_en=%b want 1/0", fifo_empty, fifo_rd_en);
        end
        push(9'h1FF);
        repeat (5) tick();
        n = got.size() - base;
        total++;
        if (rd_cnt - rd0 !== 1) begin
            bad++; $display("FAIL empty_reads got=%0d want=1", rd_cnt - rd0);
        end
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL empty_count got=%0d want=1", n);
        end else begin
            total++;
            if (got[base] !== 9'h1FF) begin
                bad++; $display("FAIL empty_data got=%h want=1ff", got[base]);
            end
        end
        total++;
        if (empty_rd !== 0) begin
            bad++; $display("FAIL empty_read_issued got=%0d want=0", empty_rd);
        end
    endtask

    task automatic test_flush();
        int base, n;
        m_ready = 1'b0;
        base = got.size();
        push(9'h0B0);
        push(9'h0B1);
        push(9'h0B2);
        total++;
        if (level !== 2'd1 || fifo_rd_en !== 1'b0 || m_data !== 9'h0B0) begin
            bad++; $display("FAIL flush_setup got level=%0d rd_en=%b data=%h want 1/0/0b0",
                            level, fifo_rd_en, m_data);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (m_valid !== 1'b0 || level !== 2'd0) begin
            bad++; $display("FAIL flush_clear got valid=%b level=%0d want 0/0", m_valid, level);
        end
        m_ready = 1'b1;
        repeat (6) tick();
        n = got.size() - base;
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL flush_count got=%0d want=1", n);
        end else begin
            total++;
            if (got[base] !== 9'h0B2) begin
                bad++; $display("FAIL flush_next got=%h want=0b2", got[base]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, n;
        logic [WIDTH-1:0] exp_q [6];
        exp_q = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C5, 9'h0C6, 9'h0C7};
        m_ready = 1'b0;
        base = got.size();
        for (int i = 0; i < 8; i++) push(9'h0C0 + 9'(i));
        m_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL midrst_rd_en got=%b want=0", fifo_rd_en);
        end
        tick();
        total++;
        if (m_valid !== 1'b0 || m_data !== 9'h000 || level !== 2'd0) begin
            bad++; $display("FAIL midrst_state got valid=%b data=%h level=%0d want 0/000/0",
                            m_valid, m_data, level);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_spurious got=%b want=0", m_valid);
        end
        tick();
        total++;
        if (m_valid !== 1'b1 || m_data !== 9'h0C5) begin
            bad++; $display("FAIL midrst_resume got valid=%b data=%h want 1/0c5", m_valid, m_data);
        end
        repeat (4) tick();
        n = got.size() - base;
        total++;
        if (n !== 6) begin
            bad++; $display("FAIL midrst_count got=%0d want=6", n);
        end
        for (int i = 0; i < n && i < 6; i++) begin
            total++;
            if (got[base+i] !== exp_q[i]) begin
                bad++; $display("FAIL midrst_data idx=%0d got=%h want=%h", i, got[base+i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        f_wr    = 1'b0;
        f_wdata = '0;
        f_clr   = 1'b1;
        tick();
        tick();
        f_clr   = 1'b0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_flush();
        test_reset_mid();

        total++;
        if (empty_rd !== 0) begin
            bad++; $display("FAIL final_empty_reads got=%0d want=0", empty_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
